ps2_rx: RTL

PS/2 device-to-host receiver feeding the keyboard controller's scan-code input (8-bit byte plus a one-cycle valid strobe).
- Synchronises and deglitches the raw PS2_CLK/PS2_DAT pins.
- Deserialises 11-bit frames and checks start, parity and stop bits.
- Emits each good byte on the clk_bus domain; reports bad frames on separate error strobes.
- Receive-only; never drives the PS/2 lines.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_filter.sv | 68 ++++++
 rtl/ps2_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef logic [7:0] ps2_byte_t;

  // A PS/2 frame is good when the data bits plus the parity bit hold an odd number of ones.
  function automatic logic parity_ok(input ps2_byte_t b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 pin conditioning: two-flop synchronisers, clock deglitch counter,
// a data delay line matching the clock filter depth, and a falling-edge pulse.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_bus,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat,
  output logic fall
);

  logic                  clk_s1, clk_s2;
  logic                  dat_s1, dat_s2;
  logic                  filt;
  logic [7:0]            cnt;
  logic [FILTER_LEN-1:0] dly;

  // Bring both raw pins into the clk_bus domain; the idle line level is high.
  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock only flips after FILTER_LEN consecutive differing samples; fall marks a 1->0 flip.
  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt) begin
        cnt <= '0;
      end else if (cnt == 8'(FILTER_LEN - 1)) begin
        filt <= ~filt;
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Delay data by the filter depth so the sample at fall is the level seen at the raw clock edge.
  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      dly <= '1;
    end else begin
      dly <= {dly[FILTER_LEN-2:0], dat_s2};
    end
  end

  assign dat = dly[FILTER_LEN-1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames and strobes good bytes or errors.
// Optional frame watchdog is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       clk_bus,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       valid,
  output logic       err_parity,
  output logic       err_frame
);

  ps2_state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  ps2_byte_t  shreg, shreg_nx, data_nx;
  logic       par, par_nx;
  logic       valid_nx, errp_nx, errf_nx;
  logic       dat, fall;
  logic       expire;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_bus(clk_bus),
    .reset  (reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .dat    (dat),
    .fall   (fall)
  );

`ifdef PS2_RX_TIMEOUT_EN
  logic [15:0] wd;

  assign expire = (state != IDLE) && !fall && (wd == 16'(TIMEOUT_CYC));

  // Watchdog counts cycles since the last edge while a frame is open; an edge always wins over expiry.
  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      wd <= '0;
    end else if (fall || state == IDLE || expire) begin
      wd <= '0;
    end else begin
      wd <= wd + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign expire         = 1'b0;
`endif

  // Frame state and registered outputs.
  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      par        <= par_nx;
      data       <= data_nx;
      valid      <= valid_nx;
      err_parity <= errp_nx;
      err_frame  <= errf_nx;
    end
  end

  // Advance the frame on each filtered falling edge; stop-bit errors outrank parity errors.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    par_nx   = par;
    data_nx  = data;
    valid_nx = 1'b0;
    errp_nx  = 1'b0;
    errf_nx  = 1'b0;
    if (expire) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      errf_nx  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat) begin
            state_nx = DATA;
            cnt_nx   = '0;
          end
        end
        DATA: begin
          shreg_nx[cnt] = dat;
          cnt_nx        = cnt + 3'd1;
          if (cnt == 3'(DATA_BITS - 1)) begin
            state_nx = PARITY;
          end
        end
        PARITY: begin
          par_nx   = dat;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (!dat) begin
            errf_nx = 1'b1;
          end else if (parity_ok(shreg, par)) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
          end else begin
            errp_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
